// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
// video_pattern_gen : video timing + test-pattern generator (noise, colour
//                     bars, grid, ramp) with NTSC/PAL vertical timing.
// Revision: 1.0
// ============================================================================
module video_pattern_gen #(
   parameter int CE_DIV   = 4,
   parameter int H_ACTIVE = 320,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 32,
   parameter int H_BP     = 48,
   parameter int V_ACT_N  = 240,
   parameter int V_TOT_N  = 262,
   parameter int V_ACT_P  = 288,
   parameter int V_TOT_P  = 312,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 3,
   parameter int COLOR_W  = 8
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic               pal,
   input  logic [1:0]         mode,
   output logic               ce_pix,
   output logic               hsync,
   output logic               hblank,
   output logic               vsync,
   output logic               vblank,
   output logic [COLOR_W-1:0] r,
   output logic [COLOR_W-1:0] g,
   output logic [COLOR_W-1:0] b,
   output logic [7:0]         frame_cnt
);
   localparam int C_H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int C_V_MAX = (V_TOT_P > V_TOT_N) ? V_TOT_P : V_TOT_N;
   localparam int C_DW    = $clog2(CE_DIV);
   localparam int C_HW    = $clog2(C_H_TOT);
   localparam int C_VW    = $clog2(C_V_MAX);
   localparam int C_BAR_W = H_ACTIVE / 8;
   localparam int C_BW    = $clog2(C_BAR_W);

   localparam logic [C_DW-1:0] C_DIV_LAST  = C_DW'(CE_DIV - 1);
   localparam logic [C_HW-1:0] C_H_LAST    = C_HW'(C_H_TOT - 1);
   localparam logic [C_VW-1:0] C_V_LAST_N  = C_VW'(V_TOT_N - 1);
   localparam logic [C_VW-1:0] C_V_LAST_P  = C_VW'(V_TOT_P - 1);
   localparam logic [C_BW-1:0] C_BAR_LAST  = C_BW'(C_BAR_W - 1);

   logic [C_DW-1:0]    div_q, div_d;
   logic               ce_pix_q, ce_pix_d;
   logic [C_HW-1:0]    hcnt_q, hcnt_d;
   logic [C_VW-1:0]    vcnt_q, vcnt_d;
   logic [7:0]         frame_cnt_q, frame_cnt_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic               pal_q, pal_d;
   logic [1:0]         mode_q, mode_d;
   logic [C_BW-1:0]    bar_sub_q, bar_sub_d;
   logic [2:0]         bar_idx_q, bar_idx_d;
   logic               hsync_q, hsync_d;
   logic               hblank_q, hblank_d;
   logic               vsync_q, vsync_d;
   logic               vblank_q, vblank_d;
   logic [COLOR_W-1:0] r_q, r_d;
   logic [COLOR_W-1:0] g_q, g_d;
   logic [COLOR_W-1:0] b_q, b_d;

   logic               w_tick;
   logic               w_h_last;
   logic               w_v_last;
   logic               w_grid;
   logic [31:0]        w_h32;
   logic [31:0]        w_v32;
   logic [31:0]        w_v_act;
   logic [COLOR_W-1:0] w_ramp;

   // Counter next-state; the frame in progress always finishes with pal_q.
   always_comb begin
      w_tick      = (div_q == C_DIV_LAST);
      w_h_last    = (hcnt_q == C_H_LAST);
      w_v_last    = pal_q ? (vcnt_q == C_V_LAST_P) : (vcnt_q == C_V_LAST_N);
      div_d       = w_tick ? '0 : div_q + 1'b1;
      ce_pix_d    = w_tick;
      hcnt_d      = hcnt_q;
      vcnt_d      = vcnt_q;
      frame_cnt_d = frame_cnt_q;
      lfsr_d      = lfsr_q;
      pal_d       = pal_q;
      mode_d      = mode_q;
      bar_sub_d   = bar_sub_q;
      bar_idx_d   = bar_idx_q;
      if (w_tick) begin
         lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
         hcnt_d = w_h_last ? '0 : hcnt_q + 1'b1;
         if (w_h_last) begin
            vcnt_d = w_v_last ? '0 : vcnt_q + 1'b1;
            if (w_v_last) begin
               pal_d       = pal;
               mode_d      = mode;
               frame_cnt_d = frame_cnt_q + 1'b1;
            end
         end
         if (w_h_last) begin
            bar_sub_d = '0;
            bar_idx_d = '0;
         end else if (bar_sub_q == C_BAR_LAST) begin
            bar_sub_d = '0;
            bar_idx_d = bar_idx_q + 1'b1;
         end else begin
            bar_sub_d = bar_sub_q + 1'b1;
         end
      end
   end

   assign w_h32 = 32'(hcnt_d);
   assign w_v32 = 32'(vcnt_d);

   generate
      if (COLOR_W > C_HW) begin : g_ramp_pad
         assign w_ramp = {{(COLOR_W - C_HW){1'b0}}, hcnt_d};
      end else begin : g_ramp_trunc
         assign w_ramp = hcnt_d[COLOR_W-1:0];
      end
   endgenerate

   // Decodes and colour for the new counter values, updated only on a tick.
   always_comb begin
      hsync_d  = hsync_q;
      hblank_d = hblank_q;
      vsync_d  = vsync_q;
      vblank_d = vblank_q;
      r_d      = r_q;
      g_d      = g_q;
      b_d      = b_q;
      w_grid   = 1'b0;
      w_v_act  = pal_d ? 32'(V_ACT_P) : 32'(V_ACT_N);
      if (w_tick) begin
         hblank_d = (w_h32 >= 32'(H_ACTIVE));
         hsync_d  = (w_h32 >= 32'(H_ACTIVE + H_FP)) &&
                    (w_h32 <  32'(H_ACTIVE + H_FP + H_SYNC));
         vblank_d = (w_v32 >= w_v_act);
         vsync_d  = (w_v32 >= w_v_act + 32'(V_FP)) &&
                    (w_v32 <  w_v_act + 32'(V_FP + V_SYNC));
         w_grid   = (hcnt_d[3:0] == 4'd0) || (vcnt_d[3:0] == 4'd0);
         case (mode_d)
            2'd0: begin
               r_d = lfsr_d[COLOR_W-1:0];
               g_d = lfsr_d[COLOR_W-1:0];
               b_d = lfsr_d[COLOR_W-1:0];
            end
            2'd1: begin
               r_d = {COLOR_W{~bar_idx_d[1]}};
               g_d = {COLOR_W{~bar_idx_d[2]}};
               b_d = {COLOR_W{~bar_idx_d[0]}};
            end
            2'd2: begin
               r_d = {COLOR_W{w_grid}};
               g_d = {COLOR_W{w_grid}};
               b_d = {COLOR_W{w_grid}};
            end
            default: begin
               r_d = w_ramp;
               g_d = w_ramp;
               b_d = w_ramp;
            end
         endcase
         if (hblank_d || vblank_d) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         div_q       <= '0;
         ce_pix_q    <= 1'b0;
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         frame_cnt_q <= '0;
         lfsr_q      <= 16'hACE1;
         pal_q       <= 1'b0;
         mode_q      <= 2'd0;
         bar_sub_q   <= '0;
         bar_idx_q   <= '0;
         hsync_q     <= 1'b0;
         hblank_q    <= 1'b0;
         vsync_q     <= 1'b0;
         vblank_q    <= 1'b0;
         r_q         <= '0;
         g_q         <= '0;
         b_q         <= '0;
      end else begin
         div_q       <= div_d;
         ce_pix_q    <= ce_pix_d;
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         frame_cnt_q <= frame_cnt_d;
         lfsr_q      <= lfsr_d;
         pal_q       <= pal_d;
         mode_q      <= mode_d;
         bar_sub_q   <= bar_sub_d;
         bar_idx_q   <= bar_idx_d;
         hsync_q     <= hsync_d;
         hblank_q    <= hblank_d;
         vsync_q     <= vsync_d;
         vblank_q    <= vblank_d;
         r_q         <= r_d;
         g_q         <= g_d;
         b_q         <= b_d;
      end
   end

   assign ce_pix    = ce_pix_q;
   assign hsync     = hsync_q;
   assign hblank    = hblank_q;
   assign vsync     = vsync_q;
   assign vblank    = vblank_q;
   assign r         = r_q;
   assign g         = g_q;
   assign b         = b_q;
   assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`default_nettype none
// ============================================================================
// tb_video_pattern_gen : scoreboard bench for video_pattern_gen, reduced
//                        geometry, reference model works on a linear pixel index.
// Revision: 1.0
// ============================================================================
module tb_video_pattern_gen;
   localparam int CE_DIV   = 2;
   localparam int H_ACTIVE = 32;
   localparam int H_FP     = 4;
   localparam int H_SYNC   = 4;
   localparam int H_BP     = 8;
   localparam int V_ACT_N  = 20;
   localparam int V_TOT_N  = 30;
   localparam int V_ACT_P  = 24;
   localparam int V_TOT_P  = 36;
   localparam int V_FP     = 2;
   localparam int V_SYNC   = 3;
   localparam int COLOR_W  = 8;
   localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;

   logic         clk_sys = 1'b0;
   logic         reset;
   logic         pal;
   logic [1:0]   mode;
   logic         ce_pix, hsync, hblank, vsync, vblank;
   logic [7:0]   r, g, b;
   logic [7:0]   frame_cnt;

   video_pattern_gen #(
      .CE_DIV(CE_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACT_N(V_ACT_N), .V_TOT_N(V_TOT_N), .V_ACT_P(V_ACT_P), .V_TOT_P(V_TOT_P),
      .V_FP(V_FP), .V_SYNC(V_SYNC), .COLOR_W(COLOR_W)
   ) dut (
      .clk_sys(clk_sys), .reset(reset), .pal(pal), .mode(mode),
      .ce_pix(ce_pix), .hsync(hsync), .hblank(hblank), .vsync(vsync), .vblank(vblank),
      .r(r), .g(g), .b(b), .frame_cnt(frame_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      int       h;
      int       v;
      bit       hs, hb, vs, vb;
      bit [7:0] r, g, b;
      bit [7:0] fc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state: position is a linear index into the frame.
   int       m_cyc, m_p, m_fc, m_vtot, m_vact, m_idx;
   bit       m_pal;
   bit [1:0] m_mode;
   bit [15:0] m_lfsr;
   bit [2:0] m_f;
   exp_t     m_e;
   exp_t     mon_e;

   function automatic bit [15:0] lfsr_next(input bit [15:0] x);
      return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic bit [2:0] bar_rgb(input int idx);
      case (idx)
         0: return 3'b111;
         1: return 3'b110;
         2: return 3'b011;
         3: return 3'b010;
         4: return 3'b101;
         5: return 3'b100;
         6: return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   task automatic chk(input string name, input int h, input int v,
                      input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s at h=%0d v=%0d: got %0h expected %0h", name, h, v, act, want);
      end
   endtask

   always @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         m_cyc  = 0;
         m_p    = 0;
         m_fc   = 0;
         m_pal  = 1'b0;
         m_mode = 2'd0;
         m_lfsr = 16'hACE1;
         exp_q.delete();
      end else begin
         m_cyc++;
         if (m_cyc % CE_DIV == 0) begin
            m_vtot = m_pal ? V_TOT_P : V_TOT_N;
            if (m_p == H_TOT * m_vtot - 1) begin
               m_p    = 0;
               m_pal  = pal;
               m_mode = mode;
               m_fc   = (m_fc + 1) % 256;
            end else begin
               m_p++;
            end
            m_lfsr = lfsr_next(m_lfsr);
            m_e.h  = m_p % H_TOT;
            m_e.v  = m_p / H_TOT;
            m_vact = m_pal ? V_ACT_P : V_ACT_N;
            m_e.hb = (m_e.h >= H_ACTIVE);
            m_e.hs = (m_e.h >= H_ACTIVE + H_FP) && (m_e.h < H_ACTIVE + H_FP + H_SYNC);
            m_e.vb = (m_e.v >= m_vact);
            m_e.vs = (m_e.v >= m_vact + V_FP) && (m_e.v < m_vact + V_FP + V_SYNC);
            m_e.r  = 8'h00;
            m_e.g  = 8'h00;
            m_e.b  = 8'h00;
            if (!m_e.hb && !m_e.vb) begin
               case (m_mode)
                  2'd0: begin
                     m_e.r = m_lfsr[7:0]; m_e.g = m_lfsr[7:0]; m_e.b = m_lfsr[7:0];
                  end
                  2'd1: begin
                     m_idx = m_e.h / (H_ACTIVE / 8);
                     m_f   = bar_rgb(m_idx);
                     m_e.r = m_f[2] ? 8'hFF : 8'h00;
                     m_e.g = m_f[1] ? 8'hFF : 8'h00;
                     m_e.b = m_f[0] ? 8'hFF : 8'h00;
                  end
                  2'd2: begin
                     if ((m_e.h % 16 == 0) || (m_e.v % 16 == 0)) begin
                        m_e.r = 8'hFF; m_e.g = 8'hFF; m_e.b = 8'hFF;
                     end
                  end
                  default: begin
                     m_e.r = 8'(m_e.h); m_e.g = 8'(m_e.h); m_e.b = 8'(m_e.h);
                  end
               endcase
            end
            m_e.fc = 8'(m_fc);
            exp_q.push_back(m_e);
         end
      end
   end

   always @(negedge clk_sys) begin
      if (reset === 1'b0) begin
         chk("ce_pix", -1, -1, 32'(ce_pix), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            if (ce_pix === 1'b1) begin
               chk("timing{hs,hb,vs,vb}", mon_e.h, mon_e.v, 32'({hsync, hblank, vsync, vblank}),
                   32'({mon_e.hs, mon_e.hb, mon_e.vs, mon_e.vb}));
               chk("rgb", mon_e.h, mon_e.v, 32'({r, g, b}), 32'({mon_e.r, mon_e.g, mon_e.b}));
               chk("frame_cnt", mon_e.h, mon_e.v, 32'(frame_cnt), 32'(mon_e.fc));
            end
         end
      end
   end

   task automatic wait_frame();
      logic [7:0] start;
      int n;
      start = frame_cnt;
      n = 0;
      while (frame_cnt === start && n < 4000) begin
         @(negedge clk_sys);
         n++;
      end
      if (frame_cnt === start) begin
         total++;
         bad++;
         $display("FAIL frame_wait: frame_cnt stuck at %0d, expected change within 4000 cycles", start);
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: time limit reached, expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      pal   = 1'b0;
      mode  = 2'd0;
      repeat (3) @(negedge clk_sys);
      chk("reset ctrl", -1, -1, 32'({ce_pix, hsync, hblank, vsync, vblank}), 32'd0);
      chk("reset rgb", -1, -1, 32'({r, g, b}), 32'd0);
      chk("reset frame_cnt", -1, -1, 32'(frame_cnt), 32'd0);
      reset = 1'b0;

      // Random mid-frame noise on pal/mode, then the value meant for the next frame.
      for (int k = 0; k < 12; k++) begin
         repeat ($urandom_range(100, 2000)) @(negedge clk_sys);
         mode = 2'($urandom_range(0, 3));
         pal  = 1'($urandom_range(0, 1));
         repeat (200) @(negedge clk_sys);
         mode = 2'(k % 4);
         pal  = 1'((k / 4) % 2);
         wait_frame();
      end

      repeat ($urandom_range(300, 600)) @(negedge clk_sys);
      #2 reset = 1'b1;
      #1;
      chk("async reset ctrl", -1, -1, 32'({ce_pix, hsync, hblank, vsync, vblank}), 32'd0);
      chk("async reset rgb", -1, -1, 32'({r, g, b}), 32'd0);
      chk("async reset frame_cnt", -1, -1, 32'(frame_cnt), 32'd0);
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
      mode  = 2'd3;
      pal   = 1'b1;
      wait_frame();
      wait_frame();
      repeat (10) @(negedge clk_sys);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
